isa_io_cycle: RTL and testbench

- Downstream ISA bus-cycle engine for the riser's DSP sequencers (reset, command, read).
- Turns a single-cycle request (address, write data, direction) into a timed 8-bit ISA I/O read or write on SA/SD with IOR_n/IOW_n strobes.
- Honours IOCHRDY wait states, with a timeout.
- Returns read data and a completion pulse that the upstream sequencers use as data_in and as their advance condition.

---
 rtl/isa_io_cycle_pkg.sv | 31 +++
 rtl/isa_io_cycle_sync2.sv | 22 ++
 rtl/isa_io_cycle.sv | 183 ++++++++++++++++++
 tb/tb_isa_io_cycle.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_io_cycle_pkg.sv
// Shared definitions for the ISA I/O cycle engine: state encodings, direction
// values, sound-blaster port offsets and the read value reported on timeout.
package isa_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_STROBE   = 3'd2;
    localparam logic [2:0] ST_WAIT_RDY = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_RECOVER  = 3'd5;

    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    localparam logic [3:0] SB_RESET  = 4'h6;
    localparam logic [3:0] SB_READ   = 4'hA;
    localparam logic [3:0] SB_WRITE  = 4'hC;
    localparam logic [3:0] SB_STATUS = 4'hE;

    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

    // Terminal value of a phase counter that runs for clks cycles starting at 0.
    function automatic logic [3:0] phase_last(input int clks);
        if (clks <= 0) begin
            return 4'd0;
        end else begin
            return 4'(clks - 1);
        end
    endfunction

endpackage

// File: rtl/isa_io_cycle_sync2.sv
// Two-flop synchroniser for the asynchronous IOCHRDY line; resets to "ready".
module isa_sync2 (
    input  logic bus_clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage resynchronisation into the bus_clock domain.
    always_ff @(posedge bus_clock) begin
        if (reset) begin
            meta_r <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/isa_io_cycle.sv
// ISA 8-bit I/O bus-cycle engine: turns a one-cycle request into a timed
// IOR_n/IOW_n cycle with IOCHRDY wait states, timeout and a done pulse.
module isa_io_cycle
    import isa_pkg::*;
#(
    parameter int ADDR_SETUP_CLKS  = 1,
    parameter int STROBE_CLKS      = 4,
    parameter int RECOVERY_CLKS    = 2,
    parameter int RDY_TIMEOUT_CLKS = 64
) (
    input  logic        bus_clock,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        dir,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        timeout,
    output logic [15:0] sa,
    output logic        aen,
    output logic        ior_n,
    output logic        iow_n,
    output logic [7:0]  sd_out,
    output logic        sd_oe,
    input  logic [7:0]  sd_in,
    input  logic        iochrdy
);

    if (ADDR_SETUP_CLKS < 1 || ADDR_SETUP_CLKS > 15 ||
        STROBE_CLKS < 1 || STROBE_CLKS > 15 ||
        RECOVERY_CLKS < 0 || RECOVERY_CLKS > 15 ||
        RDY_TIMEOUT_CLKS < 1 || RDY_TIMEOUT_CLKS > 255) begin : g_param_check
        $error("isa_io_cycle: timing parameter out of range");
    end

    localparam logic [3:0] SETUP_LAST  = phase_last(ADDR_SETUP_CLKS);
    localparam logic [3:0] STROBE_LAST = phase_last(STROBE_CLKS);
    localparam logic [3:0] REC_LAST    = phase_last(RECOVERY_CLKS);
    localparam logic [7:0] WAIT_LAST   = 8'(RDY_TIMEOUT_CLKS - 1);

    logic [2:0] state_r;
    logic [3:0] phase_r;
    logic [7:0] wait_cnt_r;
    logic       dir_r;
    logic       rdy_sync_s;
    logic       strobe_end_s;
    logic       timeout_hit_s;
    logic       unused_wdata_s;

    assign unused_wdata_s = ^wdata[15:8];

    isa_sync2 u_rdy_sync (
        .bus_clock (bus_clock),
        .reset     (reset),
        .d         (iochrdy),
        .q         (rdy_sync_s)
    );

    // Decide whether this edge releases the strobe, and whether by timeout.
    always_comb begin
        strobe_end_s  = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_STROBE: begin
                strobe_end_s = (phase_r == STROBE_LAST) && rdy_sync_s;
            end
            ST_WAIT_RDY: begin
                if (rdy_sync_s) begin
                    strobe_end_s = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    strobe_end_s  = 1'b1;
                    timeout_hit_s = 1'b1;
                end else begin
                    strobe_end_s = 1'b0;
                end
            end
            default: begin
                strobe_end_s = 1'b0;
            end
        endcase
    end

    // Cycle sequencer; bus outputs are set on the edge that enters each phase.
    always_ff @(posedge bus_clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            phase_r    <= 4'd0;
            wait_cnt_r <= 8'd0;
            dir_r      <= DIR_READ;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 16'h0000;
            timeout    <= 1'b0;
            sa         <= 16'h0000;
            aen        <= 1'b1;
            ior_n      <= 1'b1;
            iow_n      <= 1'b1;
            sd_out     <= 8'h00;
            sd_oe      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (strobe_end_s) begin
                state_r <= ST_HOLD;
                ior_n   <= 1'b1;
                iow_n   <= 1'b1;
                done    <= 1'b1;
                if (timeout_hit_s) begin
                    timeout <= 1'b1;
                end
                if (dir_r == DIR_READ) begin
                    rdata <= timeout_hit_s ? {8'h00, RDATA_TIMEOUT} : {8'h00, sd_in};
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (req) begin
                            state_r <= ST_SETUP;
                            phase_r <= 4'd0;
                            dir_r   <= dir;
                            sa      <= addr;
                            sd_out  <= wdata[7:0];
                            sd_oe   <= (dir == DIR_WRITE);
                            aen     <= 1'b0;
                            busy    <= 1'b1;
                            timeout <= 1'b0;
                        end
                    end
                    ST_SETUP: begin
                        if (phase_r == SETUP_LAST) begin
                            state_r <= ST_STROBE;
                            phase_r <= 4'd0;
                            ior_n   <= (dir_r != DIR_READ);
                            iow_n   <= (dir_r != DIR_WRITE);
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                    ST_STROBE: begin
                        if (phase_r == STROBE_LAST) begin
                            state_r    <= ST_WAIT_RDY;
                            wait_cnt_r <= 8'd0;
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                    ST_WAIT_RDY: begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                    ST_HOLD: begin
                        aen     <= 1'b1;
                        sd_oe   <= 1'b0;
                        phase_r <= 4'd0;
                        if (RECOVERY_CLKS == 0) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_RECOVER;
                        end
                    end
                    ST_RECOVER: begin
                        if (phase_r == REC_LAST) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        aen     <= 1'b1;
                        ior_n   <= 1'b1;
                        iow_n   <= 1'b1;
                        sd_oe   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isa_io_cycle.sv
// Randomised self-checking bench for isa_io_cycle; expected bus timing is
// derived per transaction from the cycle-latency rules.
module tb_isa_io_cycle;
    import isa_pkg::*;

    localparam int SETUP    = 1;
    localparam int STROBE   = 4;
    localparam int RECOVERY = 2;
    localparam int TO_CLKS  = 64;
    localparam int STRB_END = SETUP + STROBE;   // edge that normally ends the strobe
    localparam logic [15:0] BASE = 16'h0220;

    logic        bus_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        req       = 1'b0;
    logic [15:0] addr      = 16'h0000;
    logic [15:0] wdata     = 16'h0000;
    logic        dir       = 1'b0;
    logic [7:0]  sd_in     = 8'h00;
    logic        iochrdy   = 1'b1;
    logic        busy, done, timeout, aen, ior_n, iow_n, sd_oe;
    logic [15:0] rdata, sa;
    logic [7:0]  sd_out;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl_rdata;
    logic        mdl_timeout;

    always #5 bus_clock = ~bus_clock;

    isa_io_cycle #(
        .ADDR_SETUP_CLKS  (SETUP),
        .STROBE_CLKS      (STROBE),
        .RECOVERY_CLKS    (RECOVERY),
        .RDY_TIMEOUT_CLKS (TO_CLKS)
    ) dut (
        .bus_clock (bus_clock),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .wdata     (wdata),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .sa        (sa),
        .aen       (aen),
        .ior_n     (ior_n),
        .iow_n     (iow_n),
        .sd_out    (sd_out),
        .sd_oe     (sd_oe),
        .sd_in     (sd_in),
        .iochrdy   (iochrdy)
    );

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge bus_clock);
        #1;
    endtask

    // One transaction; cycle k is the cycle after edge k-1, edge 0 accepts req.
    // rdy_edge: first edge at which raw iochrdy is sampled high.
    task automatic do_txn(input logic [15:0] a, input logic [7:0] d, input logic wr,
                          input int rdy_edge, input bit rand_sd, input logic [7:0] sd_fix,
                          input bit hold_req, input int abort_k);
        int   exit_e;
        int   last_k;
        bit   to;
        bit   low;
        bit   owned;
        logic [7:0] cap;
        exit_e = (rdy_edge + 2 > STRB_END) ? rdy_edge + 2 : STRB_END;
        to = 1'b0;
        if (exit_e > STRB_END + TO_CLKS) begin
            exit_e = STRB_END + TO_CLKS;
            to = 1'b1;
        end
        last_k = exit_e + 1 + RECOVERY;
        cap = sd_fix;
        for (int k = 0; k <= last_k; k++) begin
            if (k >= 1) begin
                low   = (k >= SETUP + 1) && (k <= exit_e);
                owned = (k <= exit_e + 1);
                check_eq($sformatf("busy@%0d", k), {15'd0, busy}, 16'd1);
                check_eq($sformatf("aen@%0d", k), {15'd0, aen}, {15'd0, !owned});
                check_eq($sformatf("ior_n@%0d", k), {15'd0, ior_n}, {15'd0, !(low && !wr)});
                check_eq($sformatf("iow_n@%0d", k), {15'd0, iow_n}, {15'd0, !(low && wr)});
                check_eq($sformatf("sd_oe@%0d", k), {15'd0, sd_oe}, {15'd0, owned && wr});
                check_eq($sformatf("done@%0d", k), {15'd0, done}, {15'd0, k == exit_e + 1});
                check_eq($sformatf("rdata@%0d", k), rdata, mdl_rdata);
                check_eq($sformatf("timeout@%0d", k), {15'd0, timeout}, {15'd0, mdl_timeout});
                if (owned) begin
                    check_eq($sformatf("sa@%0d", k), sa, a);
                    if (wr) begin
                        check_eq($sformatf("sd_out@%0d", k), {8'h00, sd_out}, {8'h00, d});
                    end
                end
            end
            if (k == 0) begin
                req   = 1'b1;
                addr  = a;
                wdata = {8'($urandom), d};
                dir   = wr;
            end else begin
                req   = hold_req | ($urandom_range(0, 3) == 0);
                addr  = 16'($urandom);
                wdata = 16'($urandom);
                dir   = 1'($urandom);
            end
            iochrdy = (k >= rdy_edge);
            sd_in   = rand_sd ? 8'($urandom) : sd_fix;
            if (k == exit_e) cap = sd_in;
            if (k == abort_k) reset = 1'b1;
            tick();
            if (k == abort_k) begin
                check_eq("rst_ior_n", {15'd0, ior_n}, 16'd1);
                check_eq("rst_iow_n", {15'd0, iow_n}, 16'd1);
                check_eq("rst_aen", {15'd0, aen}, 16'd1);
                check_eq("rst_sd_oe", {15'd0, sd_oe}, 16'd0);
                check_eq("rst_busy", {15'd0, busy}, 16'd0);
                check_eq("rst_done", {15'd0, done}, 16'd0);
                reset = 1'b0;
                req   = 1'b0;
                mdl_rdata   = 16'h0000;
                mdl_timeout = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check_eq($sformatf("post_rst_done%0d", j), {15'd0, done}, 16'd0);
                    check_eq($sformatf("post_rst_busy%0d", j), {15'd0, busy}, 16'd0);
                end
                return;
            end
            if (k == 0) mdl_timeout = 1'b0;
            if (k == exit_e) begin
                mdl_timeout = to;
                if (!wr) mdl_rdata = to ? {8'h00, RDATA_TIMEOUT} : {8'h00, cap};
            end
        end
        check_eq("idle_busy", {15'd0, busy}, 16'd0);
        check_eq("idle_aen", {15'd0, aen}, 16'd1);
        check_eq("idle_done", {15'd0, done}, 16'd0);
        req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        int re;
        logic [3:0] offs [4];
        offs[0] = SB_RESET;
        offs[1] = SB_READ;
        offs[2] = SB_WRITE;
        offs[3] = SB_STATUS;

        reset = 1'b1;
        repeat (3) tick();
        check_eq("reset_busy", {15'd0, busy}, 16'd0);
        check_eq("reset_done", {15'd0, done}, 16'd0);
        check_eq("reset_rdata", rdata, 16'h0000);
        check_eq("reset_timeout", {15'd0, timeout}, 16'd0);
        check_eq("reset_sa", sa, 16'h0000);
        check_eq("reset_aen", {15'd0, aen}, 16'd1);
        check_eq("reset_ior_n", {15'd0, ior_n}, 16'd1);
        check_eq("reset_iow_n", {15'd0, iow_n}, 16'd1);
        check_eq("reset_sd_out", {8'h00, sd_out}, 16'h0000);
        check_eq("reset_sd_oe", {15'd0, sd_oe}, 16'd0);
        reset = 1'b0;
        mdl_rdata   = 16'h0000;
        mdl_timeout = 1'b0;
        tick();

        do_txn(BASE + {12'h000, SB_RESET}, 8'h01, DIR_WRITE, 0, 1'b0, 8'h00, 1'b0, -1);
        do_txn(BASE + {12'h000, SB_STATUS}, 8'h00, DIR_READ, 0, 1'b0, 8'h80, 1'b0, -1);
        do_txn(BASE + {12'h000, SB_READ}, 8'h00, DIR_READ, 10, 1'b1, 8'h00, 1'b0, -1);
        do_txn(BASE + {12'h000, SB_READ}, 8'h00, DIR_READ, 1000, 1'b1, 8'h00, 1'b0, -1);
        do_txn(BASE + {12'h000, SB_STATUS}, 8'h00, DIR_READ, 0, 1'b0, 8'h5A, 1'b0, -1);
        do_txn(BASE + {12'h000, SB_WRITE}, 8'hD1, DIR_WRITE, 1000, 1'b1, 8'h00, 1'b0, -1);
        do_txn(BASE + {12'h000, SB_READ}, 8'h00, DIR_READ, 0, 1'b1, 8'h00, 1'b0, 4);
        repeat (3) do_txn(BASE + {12'h000, SB_WRITE}, 8'($urandom), DIR_WRITE, 0, 1'b1, 8'h00, 1'b1, -1);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       re = 0;
            else if (sel < 9)  re = $urandom_range(3, 14);
            else               re = 1000;
            do_txn(BASE + {12'h000, offs[$urandom_range(0, 3)]}, 8'($urandom), 1'($urandom),
                   re, 1'b1, 8'h00, 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
